// File: rtl/rom_uart_pkg.sv
// Shared FSM encodings, framing constants and width helper for the ROM UART dump path.
package rom_uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        DONE
    } dump_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_FRAME
    } tx_state_t;

    // Ceiling log2 for value >= 1; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned result;
        v      = value - 1;
        result = 0;
        while (v != 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, LSB-first data, stop bit, then a one-cycle byte_done.
module uart_tx_byte
    import rom_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      send,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      tx,
    output logic                      byte_done
);

    localparam int unsigned FRAME_BITS = UART_DATA_BITS + 2;
    localparam int unsigned BAUD_W     = clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W      = clog2(FRAME_BITS);

    tx_state_t                 state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS:0]   shift_q, shift_d;
    logic                      tx_d;
    logic                      byte_done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '1;
            tx        <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx        <= tx_d;
            byte_done <= byte_done_d;
        end
    end

    // The byte_done cycle is already idle, so a back-to-back send leaves exactly one idle-high cycle.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx;
        byte_done_d = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (send) begin
                    shift_d = {1'b1, data};
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_FRAME;
                end
            end
            TX_FRAME: begin
                if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        tx_d        = 1'b1;
                        byte_done_d = 1'b1;
                        state_d     = TX_IDLE;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b1, shift_q[UART_DATA_BITS:1]};
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/rom_uart_dumper.sv
// Reads WORDS words from address 0 upward and sends each out LSB byte first over an 8N1 UART.
module rom_uart_dumper
    import rom_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned WORDS        = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = clog2(WORDS) + 1;
    localparam int unsigned IDX_W = clog2(BYTES_PER_WORD);

    dump_state_t               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          cnt_inc_c;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [31:0]               word_q, word_d;
    logic [31:0]               rd_addr_d;
    logic                      busy_d;
    logic                      done_d;
    logic                      send_c;
    logic [UART_DATA_BITS-1:0] send_data_c;
    logic                      byte_done;

    assign cnt_inc_c = cnt_q + CNT_W'(1);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .send     (send_c),
        .data     (send_data_c),
        .tx       (tx),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            rd_addr <= rd_addr_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // The first byte of a word is launched straight from rd_data in LOAD, saving a cycle per word.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        word_d      = word_q;
        rd_addr_d   = rd_addr;
        busy_d      = busy;
        done_d      = 1'b0;
        send_c      = 1'b0;
        send_data_c = UART_DATA_BITS'(word_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                word_d      = rd_data;
                idx_d       = '0;
                send_c      = 1'b1;
                send_data_c = rd_data[UART_DATA_BITS-1:0];
                state_d     = SEND;
            end
            SEND: begin
                if (byte_done) begin
                    if (idx_q != IDX_W'(BYTES_PER_WORD - 1)) begin
                        idx_d       = idx_q + IDX_W'(1);
                        send_c      = 1'b1;
                        send_data_c = UART_DATA_BITS'(word_q >> (UART_DATA_BITS * idx_d));
                    end else if (cnt_q != CNT_W'(WORDS - 1)) begin
                        cnt_d     = cnt_inc_c;
                        rd_addr_d = 32'({cnt_inc_c, 2'b00});
                        state_d   = FETCH;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rd_addr_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_uart_dumper.sv
// Bench for rom_uart_dumper: table vectors, corner sequences and random dumps against a waveform model.
module tb_rom_uart_dumper;

    localparam int A_CPB   = 4;
    localparam int A_WORDS = 2;
    localparam int B_CPB   = 2;
    localparam int B_WORDS = 1;
    localparam int MAX_CYC = 2000;
    localparam int RST_IDX = 2 + 2 * (10 * A_CPB + 1) + 4 * A_CPB;

    typedef struct {
        int          sel;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [63:0] exp_bytes;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, b_start;
    logic [31:0] a_rd_addr, b_rd_addr, a_rd_data, b_rd_data;
    logic        a_tx, b_tx, a_busy, b_busy, a_done, b_done;
    logic [31:0] mem_a [A_WORDS];
    logic [31:0] mem_b [B_WORDS];

    int checks   = 0;
    int failures = 0;

    bit          tr_tx[$];
    bit          tr_busy[$];
    bit          tr_done[$];
    logic [31:0] tr_addr[$];
    bit          ex_tx[$];
    logic [31:0] ex_addr[$];
    int          ex_done;

    always #5 clk = ~clk;

    rom_uart_dumper #(.CLKS_PER_BIT(A_CPB), .WORDS(A_WORDS)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .tx(a_tx), .busy(a_busy), .done(a_done)
    );

    rom_uart_dumper #(.CLKS_PER_BIT(B_CPB), .WORDS(B_WORDS)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .tx(b_tx), .busy(b_busy), .done(b_done)
    );

    // Memory with one cycle of read latency.
    always @(posedge clk) begin
        a_rd_data <= (a_rd_addr[31:3] == '0) ? mem_a[a_rd_addr[2]] : 32'hDEAD_BEEF;
        b_rd_data <= (b_rd_addr == 32'd0) ? mem_b[0] : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) a_start = v;
        else b_start = v;
    endtask

    task automatic push_ex(input bit t, input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            ex_tx.push_back(t);
            ex_addr.push_back(a);
        end
    endtask

    // Expected per-cycle tx and rd_addr, index 0 = first cycle after start is sampled.
    task automatic build_expected(input int cpb, input int nw, input logic [63:0] words);
        logic [7:0] byte_v;
        bit         val;
        ex_tx.delete();
        ex_addr.delete();
        push_ex(1'b1, 32'd0, 2);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                byte_v = 8'(words >> (32 * w + 8 * b));
                for (int j = 0; j < 10; j++) begin
                    if (j == 0) val = 1'b0;
                    else if (j == 9) val = 1'b1;
                    else val = byte_v[j-1];
                    push_ex(val, 32'(4 * w), cpb);
                end
                if (b < 3) begin
                    push_ex(1'b1, 32'(4 * w), 1);
                end else if (w < nw - 1) begin
                    push_ex(1'b1, 32'(4 * w), 1);
                    push_ex(1'b1, 32'(4 * (w + 1)), 2);
                end else begin
                    push_ex(1'b1, 32'(4 * w), 1);
                    ex_done = ex_tx.size();
                    push_ex(1'b1, 32'(4 * w), 1);
                end
            end
        end
    endtask

    task automatic run_dump(input int sel, input int extra_idx, input int tail);
        int left;
        bit seen;
        tr_tx.delete();
        tr_busy.delete();
        tr_done.delete();
        tr_addr.delete();
        @(negedge clk);
        drive_start(sel, 1'b1);
        seen = 1'b0;
        left = tail;
        for (int k = 0; k < MAX_CYC; k++) begin
            @(negedge clk);
            drive_start(sel, k == extra_idx);
            tr_tx.push_back(sel == 0 ? a_tx : b_tx);
            tr_busy.push_back(sel == 0 ? a_busy : b_busy);
            tr_done.push_back(sel == 0 ? a_done : b_done);
            tr_addr.push_back(sel == 0 ? a_rd_addr : b_rd_addr);
            if (tr_done[$]) seen = 1'b1;
            if (seen) begin
                if (left == 0) break;
                left--;
            end
        end
        drive_start(sel, 1'b0);
        check("dump_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic check_dump(input string tag, input int sel, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [63:0] exp_bytes);
        int          cpb, nw, n, i, nb;
        int          tx_bad, busy_bad, addr_bad, done_cnt, done_at;
        bit          e_tx;
        logic [31:0] e_addr;
        logic [63:0] words, dec;
        logic [7:0]  bv;
        cpb   = (sel == 0) ? A_CPB : B_CPB;
        nw    = (sel == 0) ? A_WORDS : B_WORDS;
        words = (nw == 1) ? {32'd0, w0} : {w1, w0};
        build_expected(cpb, nw, words);
        n = tr_tx.size();
        tx_bad = 0; busy_bad = 0; addr_bad = 0; done_cnt = 0; done_at = -1;
        for (int k = 0; k < n; k++) begin
            e_tx   = (k < ex_tx.size()) ? ex_tx[k] : 1'b1;
            e_addr = (k < ex_addr.size()) ? ex_addr[k] : 32'd0;
            if (tr_tx[k] !== e_tx) tx_bad++;
            if (tr_addr[k] !== e_addr) addr_bad++;
            if (tr_busy[k] !== (k < ex_done)) busy_bad++;
            if (tr_done[k]) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        check({tag, " tx_wave_bad_cycles"}, 64'(tx_bad), 64'd0);
        check({tag, " busy_bad_cycles"}, 64'(busy_bad), 64'd0);
        check({tag, " rd_addr_bad_cycles"}, 64'(addr_bad), 64'd0);
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " done_cycle"}, 64'(done_at), 64'(ex_done));
        // Independent UART decode: sample each bit in the middle of its period.
        nb = 0; dec = '0; i = 0;
        while (i + 10 * cpb <= n) begin
            if (tr_tx[i] == 1'b0) begin
                for (int j = 0; j < 8; j++) bv[j] = tr_tx[i + cpb * (j + 1) + cpb / 2];
                if (nb < 8) dec[8*nb +: 8] = bv;
                nb++;
                i += 10 * cpb;
            end else begin
                i++;
            end
        end
        check({tag, " byte_count"}, 64'(nb), 64'(4 * nw));
        check({tag, " bytes"}, dec, exp_bytes);
    endtask

    initial begin
        vec_t        vecs[4];
        int          bad_tx, bad_busy, bad_done, bad_addr;
        int          sel, extra, tail;
        logic [31:0] w0, w1;

        vecs[0].sel = 0; vecs[0].w0 = 32'h1234_5678; vecs[0].w1 = 32'hA5C3_0FF0;
        vecs[0].exp_bytes = 64'hA5C3_0FF0_1234_5678;
        vecs[1].sel = 1; vecs[1].w0 = 32'h0000_00FF; vecs[1].w1 = 32'h0;
        vecs[1].exp_bytes = 64'h0000_0000_0000_00FF;
        vecs[2].sel = 0; vecs[2].w0 = 32'h0000_0000; vecs[2].w1 = 32'hFFFF_FFFF;
        vecs[2].exp_bytes = 64'hFFFF_FFFF_0000_0000;
        vecs[3].sel = 1; vecs[3].w0 = 32'h8001_0203; vecs[3].w1 = 32'h0;
        vecs[3].exp_bytes = 64'h0000_0000_8001_0203;

        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        mem_a[0] = '0; mem_a[1] = '0; mem_b[0] = '0;
        repeat (3) @(negedge clk);
        check("reset tx", 64'(a_tx), 64'd1);
        check("reset busy", 64'(a_busy), 64'd0);
        check("reset done", 64'(a_done), 64'd0);
        check("reset rd_addr", 64'(a_rd_addr), 64'd0);
        rst = 1'b0;

        bad_tx = 0; bad_busy = 0; bad_done = 0; bad_addr = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (a_tx !== 1'b1 || b_tx !== 1'b1) bad_tx++;
            if (a_busy !== 1'b0 || b_busy !== 1'b0) bad_busy++;
            if (a_done !== 1'b0 || b_done !== 1'b0) bad_done++;
            if (a_rd_addr !== 32'd0 || b_rd_addr !== 32'd0) bad_addr++;
        end
        check("idle tx_bad_cycles", 64'(bad_tx), 64'd0);
        check("idle busy_bad_cycles", 64'(bad_busy), 64'd0);
        check("idle done_bad_cycles", 64'(bad_done), 64'd0);
        check("idle rd_addr_bad_cycles", 64'(bad_addr), 64'd0);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].sel == 0) begin
                mem_a[0] = vecs[v].w0; mem_a[1] = vecs[v].w1;
            end else begin
                mem_b[0] = vecs[v].w0;
            end
            run_dump(vecs[v].sel, -1, 5);
            check_dump($sformatf("vec%0d", v), vecs[v].sel, vecs[v].w0, vecs[v].w1, vecs[v].exp_bytes);
        end

        mem_a[0] = 32'h1234_5678; mem_a[1] = 32'hA5C3_0FF0;
        run_dump(0, 19, 5);
        check_dump("start_while_busy", 0, mem_a[0], mem_a[1], 64'hA5C3_0FF0_1234_5678);

        build_expected(A_CPB, A_WORDS, {mem_a[1], mem_a[0]});
        run_dump(0, ex_done, 40);
        check_dump("start_in_done", 0, mem_a[0], mem_a[1], 64'hA5C3_0FF0_1234_5678);

        run_dump(0, -1, 0);
        check_dump("b2b_first", 0, mem_a[0], mem_a[1], 64'hA5C3_0FF0_1234_5678);
        run_dump(0, -1, 5);
        check_dump("b2b_second", 0, mem_a[0], mem_a[1], 64'hA5C3_0FF0_1234_5678);

        // Reset during data bit 3 of byte 2 (0x34: that bit is 0, so tx is low there).
        @(negedge clk);
        a_start = 1'b1;
        for (int k = 0; k < RST_IDX; k++) begin
            @(negedge clk);
            a_start = 1'b0;
        end
        @(negedge clk);
        check("midframe tx_before_reset", 64'(a_tx), 64'd0);
        check("midframe busy_before_reset", 64'(a_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midframe tx_after_reset", 64'(a_tx), 64'd1);
        check("midframe busy_after_reset", 64'(a_busy), 64'd0);
        check("midframe rd_addr_after_reset", 64'(a_rd_addr), 64'd0);
        bad_tx = 0; bad_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (a_tx !== 1'b1) bad_tx++;
            if (a_done !== 1'b0) bad_done++;
        end
        check("midframe tx_low_after_reset", 64'(bad_tx), 64'd0);
        check("midframe done_after_reset", 64'(bad_done), 64'd0);
        run_dump(0, -1, 5);
        check_dump("after_reset", 0, mem_a[0], mem_a[1], 64'hA5C3_0FF0_1234_5678);

        for (int r = 0; r < 8; r++) begin
            sel = int'($urandom_range(0, 1));
            w0  = $urandom();
            w1  = $urandom();
            if (sel == 0) begin
                mem_a[0] = w0; mem_a[1] = w1;
                build_expected(A_CPB, A_WORDS, {w1, w0});
            end else begin
                mem_b[0] = w0;
                build_expected(B_CPB, B_WORDS, {32'd0, w0});
            end
            extra = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, ex_done - 1));
            tail  = int'($urandom_range(0, 3));
            run_dump(sel, extra, tail);
            check_dump($sformatf("rand%0d", r), sel, w0, w1,
                       (sel == 0) ? {w1, w0} : {32'd0, w0});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
